// File: rtl/loader_pkg.sv
// Shared types and default sizes for the front-panel memory loader.
// Contents:
//   state_t      - handshake/collection FSM states
//   ADDR_W_DEF   - default memory address width
//   DATA_W_DEF   - default memory word width (multiple of 4)
//   NIB_DEF      - hex digits per word at the default width
package loader_pkg;

  localparam int unsigned ADDR_W_DEF = 8;
  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned NIB_DEF    = DATA_W_DEF / 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COLLECT = 3'd1,
    REQ     = 3'd2,
    WRITE   = 3'd3,
    RELEASE = 3'd4
  } state_t;

endpackage

// File: rtl/key_edge.sv
// Rising-edge detector for a debounced, synchronized key level.
// Ports:
//   clk     - system clock
//   rst_n   - asynchronous active-low reset
//   level   - key level, high = pressed
//   q       - registered copy of level
//   rise_c  - combinational one-cycle pulse on a 0->1 transition
module key_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic level,
  output logic q,
  output logic rise_c
);

  // Previous-cycle copy of the key level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= 1'b0;
    end else begin
      q <= level;
    end
  end

  // A held key produces a single pulse.
  assign rise_c = level & ~q;

endmodule

// File: rtl/front_panel_loader.sv
// Front-panel memory loader: collects hex digits from the switches into a
// word and writes it to processor memory through a hold req/ack handshake.
// Optional feature macro: LOADER_AUTOINC_EN (address auto-increment after
// each write, with a sticky wrap flag).
// Ports:
//   Clk, ResetN        - clock, asynchronous active-low reset
//   Enter, SetAddr     - debounced key levels
//   Nibble             - hex digit from the switches
//   HoldAck            - processor has released its memory port
//   HoldReq            - request processor to release its memory port
//   WrEn/WrAddr/WrData - memory write port (one-cycle strobe)
//   Entry, DigitCnt    - digit shift register and digit count (display)
//   Busy               - handshake in progress (decoded from state)
//   Wrapped            - sticky address wrap flag
module front_panel_loader
  import loader_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic                          Clk,
  input  logic                          ResetN,
  input  logic                          Enter,
  input  logic                          SetAddr,
  input  logic [3:0]                    Nibble,
  input  logic                          HoldAck,
  output logic                          HoldReq,
  output logic                          WrEn,
  output logic [ADDR_W-1:0]             WrAddr,
  output logic [DATA_W-1:0]             WrData,
  output logic [DATA_W-1:0]             Entry,
  output logic [$clog2(DATA_W/4):0]     DigitCnt,
  output logic                          Busy,
  output logic                          Wrapped
);

  localparam int unsigned NIB   = DATA_W / 4;
  localparam int unsigned CNT_W = $clog2(NIB) + 1;

  state_t              state_q;
  state_t              state_d;
  logic                press;
  logic                apress;
  logic                enter_q;
  logic                set_addr_q;
  logic                accept;
  logic                last_digit;
  logic [DATA_W-1:0]   shifted;

  // Key edge detectors; they keep tracking the keys even while busy.
  key_edge u_enter_edge (
    .clk    (Clk),
    .rst_n  (ResetN),
    .level  (Enter),
    .q      (enter_q),
    .rise_c (press)
  );

  key_edge u_set_addr_edge (
    .clk    (Clk),
    .rst_n  (ResetN),
    .level  (SetAddr),
    .q      (set_addr_q),
    .rise_c (apress)
  );

  // Keys are only honoured outside the write handshake.
  assign accept     = (state_q == IDLE) || (state_q == COLLECT);
  assign last_digit = (DigitCnt == CNT_W'(NIB - 1));
  assign shifted    = {Entry[DATA_W-5:0], Nibble};
  assign Busy       = (state_q == REQ) || (state_q == WRITE) || (state_q == RELEASE);

  // State register.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; SetAddr outranks a simultaneous digit press.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, COLLECT: begin
        if (apress) begin
          state_d = IDLE;
        end else if (press) begin
          state_d = last_digit ? REQ : COLLECT;
        end
      end
      REQ: begin
        if (HoldAck) begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        state_d = RELEASE;
      end
      RELEASE: begin
        if (!HoldAck) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Handshake outputs registered from the next state so they line up with it.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      HoldReq <= 1'b0;
      WrEn    <= 1'b0;
    end else begin
      HoldReq <= (state_d == REQ) || (state_d == WRITE);
      WrEn    <= (state_d == WRITE);
    end
  end

  // Digit collection, address load and post-write bookkeeping.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      WrAddr   <= '0;
      WrData   <= '0;
      Entry    <= '0;
      DigitCnt <= '0;
      Wrapped  <= 1'b0;
    end else begin
      if (accept) begin
        if (apress) begin
          WrAddr   <= Entry[ADDR_W-1:0];
          Entry    <= '0;
          DigitCnt <= '0;
          Wrapped  <= 1'b0;
        end else if (press) begin
          Entry    <= shifted;
          DigitCnt <= DigitCnt + CNT_W'(1);
          if (last_digit) begin
            WrData <= shifted;
          end
        end
      end else if (state_q == WRITE) begin
        Entry    <= '0;
        DigitCnt <= '0;
`ifdef LOADER_AUTOINC_EN
        WrAddr <= WrAddr + ADDR_W'(1);
        if (&WrAddr) begin
          Wrapped <= 1'b1;
        end
`else
        WrAddr <= WrAddr;
`endif
      end
    end
  end

endmodule

// File: doc/front_panel_loader.md
# front_panel_loader

Front-panel memory loader: turns hex digits keyed in on the board switches into 16-bit words and writes them into processor memory at an auto-advancing address. It is the input-side counterpart of the board display path. Display shows processor words as hex digits; this block collects hex digits and turns them into processor words. It sits between the debounced key/switch conditioning and the processor memory write port, and takes the memory port from the processor through a hold request/acknowledge handshake.

## Interface
- ADDR_W, 8, memory address width
- DATA_W, 16, word width; must be a multiple of 4 (NIB = DATA_W/4 digits per word)
- Clk  in  1  system clock; all state changes on the rising edge
- ResetN  in  1  asynchronous, active-low reset
- Enter  in  1  debounced, synchronized level, high = key pressed
- SetAddr  in  1  debounced, synchronized level, high = key pressed
- Nibble  in  4  hex digit from the switches
- HoldAck  in  1  processor has stopped and released its memory port
- HoldReq  out  1  request that the processor stop and release its memory port
- WrEn  out  1  one-cycle memory write strobe
- WrAddr  out  ADDR_W  current write address
- WrData  out  DATA_W  word being written
- Entry  out  DATA_W  digit shift register, drives the display
- DigitCnt  out  $clog2(NIB)+1  number of digits entered so far
- Busy  out  1  write handshake is in progress; key presses are ignored
- Wrapped  out  1  sticky flag: the address counter has wrapped

## Operation
- Edge detect:
  - EnterQ and SetAddrQ are registered copies of Enter and SetAddr.
  - Press = Enter & ~EnterQ. APress = SetAddr & ~SetAddrQ.
  - A key held high counts as exactly one press.
- FSM states: IDLE, COLLECT, REQ, WRITE, RELEASE.
- IDLE or COLLECT, on Press:
  - Entry <= {Entry[DATA_W-5:0], Nibble} and DigitCnt increments.
  - The first press moves IDLE to COLLECT.
  - On the press that brings DigitCnt to NIB: WrData <= the shifted word and the FSM goes to REQ.
- IDLE or COLLECT, on APress:
  - WrAddr <= Entry[ADDR_W-1:0]; Entry, DigitCnt and Wrapped are cleared; the FSM goes to IDLE.
  - This works with any number of digits entered, including zero.
  - If Press and APress arrive in the same cycle, APress wins and the digit is discarded.
- REQ: HoldReq=1. Stay until HoldAck=1, then go to WRITE.
- WRITE: WrEn=1 for exactly one cycle with WrAddr/WrData stable. Next state is RELEASE.
  - On leaving WRITE, Entry and DigitCnt clear.
  - Address update on leaving WRITE is set by the Configuration macro.
- RELEASE: HoldReq=0. Stay until HoldAck=0, then go to IDLE.
- Busy = 1 in REQ, WRITE and RELEASE. Press and APress are ignored in these states, but the edge-detect registers keep tracking the inputs.
- If HoldAck is already high on entering REQ, the FSM moves to WRITE on the next edge.

## Timing
- Reset values: state IDLE, all outputs 0 (HoldReq, WrEn, WrAddr, WrData, Entry, DigitCnt, Busy, Wrapped), EnterQ=SetAddrQ=0.
- Every output is registered, except Busy, which is decoded from the state register.
- Digit latency: Enter rises before edge N. The Press is seen at edge N and Entry shows the digit after edge N.
- Write latency after the final digit press edge N, with HoldAck already high:
  - HoldReq=1 after N.
  - WrEn=1 after N+1, for one cycle.
  - HoldReq=0 after N+2.
- Reset asserted mid-handshake: HoldReq and WrEn drop immediately (asynchronously). The partial word is lost.

## Configuration
- LOADER_AUTOINC_EN defined: on leaving WRITE, WrAddr <= WrAddr+1 (modulo 2^ADDR_W). Incrementing from the all-ones address sets Wrapped.
- LOADER_AUTOINC_EN undefined: WrAddr is changed only by APress, and Wrapped stays 0.

## Structure
- Package loader_pkg holds the state enum typedef (IDLE, COLLECT, REQ, WRITE, RELEASE) and the width/NIB constants.
- Sub-module: key_edge, the register-and-AND rising-edge detector. It is instantiated twice, for Enter and SetAddr.

## Test plan
- Reset, then digits 1,2,3,4 with HoldAck tied high -> WrData=16'h1234, WrAddr=0, one WrEn pulse, final Entry=0, WrAddr=1 (AUTOINC).
- Enter held high for 20 cycles -> only one digit shifted in, DigitCnt=1.
- Digits A,5 then SetAddr -> WrAddr=8'hA5, Entry=0, DigitCnt=0. Next word is written at 8'hA5.
- With HoldAck held low for 10 cycles in REQ -> HoldReq=1 and Busy=1 the whole time, Enter presses ignored. HoldAck rises -> single WrEn pulse.
- WrAddr=8'hFF with AUTOINC, write a word -> WrAddr=0 and Wrapped=1. Without the macro -> WrAddr stays 8'hFF and Wrapped=0.
- ResetN pulsed low while in WRITE -> HoldReq=0, WrEn=0, state IDLE, all outputs 0.
